// File: rtl/finn_deadlock_pkg.sv
// rtl/finn_deadlock_pkg.sv - shared types and helpers for the FINN deadlock reporter
package finn_deadlock_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REPORT  = 2'd1,
    LATCHED = 2'd2
  } dl_state_t;

  // Ceiling log2 clamped to at least 1 so single-entry vectors stay legal.
  function automatic int clog2_min1(input longint n);
    int r;
    r = 0;
    for (int i = 0; i < 40; i++) begin
      if ((longint'(1) << i) < n) r = i + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/finn_deadlock_persist_cnt.sv
// rtl/finn_deadlock_persist_cnt.sv - per-monitor persistence counter and confirm
module finn_deadlock_persist_cnt
  import finn_deadlock_pkg::*;
#(
  parameter int HOLD_CYCLES = 1024
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic block,
  output logic confirm
);

  localparam int CW = clog2_min1(longint'(HOLD_CYCLES) + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(HOLD_CYCLES - 1);

  logic [CW-1:0] cnt;

  // Saturates one short of the window so confirm stays high while block persists.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (clear || !block) begin
      cnt <= '0;
    end else if (cnt != CNT_MAX) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign confirm = block && (cnt == CNT_MAX);

endmodule

// File: rtl/finn_deadlock_reporter.sv
// rtl/finn_deadlock_reporter.sv - debounces monitor block levels and reports the first deadlock
module finn_deadlock_reporter
  import finn_deadlock_pkg::*;
#(
  parameter int NUM_MON     = 8,
  parameter int HOLD_CYCLES = 1024,
  parameter int TS_W        = 32,
  localparam int IDX_W      = clog2_min1(longint'(NUM_MON))
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [NUM_MON-1:0] mon_block,
  input  logic               clear,
  output logic               report_valid,
  input  logic               report_ready,
  output logic [IDX_W-1:0]   report_idx,
  output logic [TS_W-1:0]    report_ts,
  output logic               deadlock,
  output logic [NUM_MON-1:0] mon_sticky
);

  logic [NUM_MON-1:0] confirm;
  logic               any_confirm;
  logic [IDX_W-1:0]   first_idx;
  logic [TS_W-1:0]    ts;
  dl_state_t          state;
  dl_state_t          state_next;

  for (genvar g = 0; g < NUM_MON; g++) begin : g_mon
    finn_deadlock_persist_cnt #(
      .HOLD_CYCLES (HOLD_CYCLES)
    ) u_cnt (
      .clock   (clock),
      .reset   (reset),
      .clear   (clear),
      .block   (mon_block[g]),
      .confirm (confirm[g])
    );
  end

  assign any_confirm = |confirm;

  // Scan downward so the lowest confirmed index is the last one written.
  always_comb begin
    first_idx = '0;
    for (int i = NUM_MON - 1; i >= 0; i--) begin
      if (confirm[i]) first_idx = IDX_W'(i);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (clear) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE:    if (any_confirm) state_next = REPORT;
        REPORT:  if (report_ready) state_next = LATCHED;
        LATCHED: state_next = LATCHED;
        default: state_next = IDLE;
      endcase
    end
  end

  // Decoded from the state register only, so no input reaches these outputs combinationally.
  always_comb begin
    report_valid = 1'b0;
    deadlock     = 1'b0;
    case (state)
      REPORT:  begin report_valid = 1'b1; deadlock = 1'b1; end
      LATCHED: deadlock = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ts         <= '0;
      report_idx <= '0;
      report_ts  <= '0;
      mon_sticky <= '0;
    end else begin
      ts <= ts + 1'b1;
      if (clear) mon_sticky <= '0;
      else       mon_sticky <= mon_sticky | confirm;
      if (!clear && (state == IDLE) && any_confirm) begin
        report_idx <= first_idx;
        report_ts  <= ts;
      end
    end
  end

endmodule

// File: tb/tb_finn_deadlock_reporter.sv
// tb/tb_finn_deadlock_reporter.sv - directed self-checking bench for finn_deadlock_reporter
module tb_finn_deadlock_reporter;

  localparam int NUM_MON = 4;
  localparam int HOLD    = 4;
  localparam int TS_W    = 32;
  localparam int IDX_W   = 2;

  logic               clock = 1'b0;
  logic               reset;
  logic [NUM_MON-1:0] mon_block;
  logic               clear;
  logic               report_valid;
  logic               report_ready;
  logic [IDX_W-1:0]   report_idx;
  logic [TS_W-1:0]    report_ts;
  logic               deadlock;
  logic [NUM_MON-1:0] mon_sticky;

  int checks = 0;
  int errors = 0;
  int cyc;
  int nvalid;

  finn_deadlock_reporter #(
    .NUM_MON     (NUM_MON),
    .HOLD_CYCLES (HOLD),
    .TS_W        (TS_W)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .mon_block    (mon_block),
    .clear        (clear),
    .report_valid (report_valid),
    .report_ready (report_ready),
    .report_idx   (report_idx),
    .report_ts    (report_ts),
    .deadlock     (deadlock),
    .mon_sticky   (mon_sticky)
  );

  always #5 clock = ~clock;

  // Cycle index since reset release; cycle 0 is the period right after release.
  always @(posedge clock or posedge reset) begin
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Advance to just after the edge that starts cycle n.
  task automatic goto(input int n);
    int guard;
    guard = 0;
    while (cyc != n && guard < 2000) begin
      @(posedge clock);
      #1;
      guard++;
    end
    if (cyc != n) check_eq("goto_timeout", 64'(cyc), 64'(n));
  endtask

  initial begin
    reset        = 1'b1;
    mon_block    = '0;
    clear        = 1'b0;
    report_ready = 1'b1;
    #3;
    check_eq("rst_valid",    64'(report_valid), 64'd0);
    check_eq("rst_idx",      64'(report_idx),   64'd0);
    check_eq("rst_ts",       64'(report_ts),    64'd0);
    check_eq("rst_deadlock", 64'(deadlock),     64'd0);
    check_eq("rst_sticky",   64'(mon_sticky),   64'd0);
    #9 reset = 1'b0;

    // Single monitor, ready high: one-cycle report at 14 with ts 13.
    goto(10); mon_block = 4'b0100;
    goto(13); @(negedge clock);
    check_eq("t1_valid_13",    64'(report_valid), 64'd0);
    check_eq("t1_deadlock_13", 64'(deadlock),     64'd0);
    check_eq("t1_sticky_13",   64'(mon_sticky),   64'd0);
    goto(14); @(negedge clock);
    check_eq("t1_valid_14",    64'(report_valid), 64'd1);
    check_eq("t1_idx",         64'(report_idx),   64'd2);
    check_eq("t1_ts",          64'(report_ts),    64'd13);
    check_eq("t1_deadlock_14", 64'(deadlock),     64'd1);
    check_eq("t1_sticky_14",   64'(mon_sticky),   64'b0100);
    goto(15); @(negedge clock);
    check_eq("t1_valid_15",    64'(report_valid), 64'd0);
    check_eq("t1_deadlock_15", 64'(deadlock),     64'd1);

    // LATCHED: monitor 0 confirms at 19, only the sticky bit changes.
    goto(16); mon_block = 4'b0101;
    nvalid = 0;
    for (int c = 16; c <= 21; c++) begin
      goto(c); @(negedge clock);
      if (report_valid) nvalid++;
    end
    check_eq("t4_no_valid", 64'(nvalid),     64'd0);
    check_eq("t4_sticky",   64'(mon_sticky), 64'b0101);
    check_eq("t4_idx",      64'(report_idx), 64'd2);
    check_eq("t4_ts",       64'(report_ts),  64'd13);
    check_eq("t4_deadlock", 64'(deadlock),   64'd1);
    goto(22); mon_block = '0; clear = 1'b1;
    goto(23); clear = 1'b0; @(negedge clock);
    check_eq("clr_valid",    64'(report_valid), 64'd0);
    check_eq("clr_deadlock", 64'(deadlock),     64'd0);
    check_eq("clr_sticky",   64'(mon_sticky),   64'd0);

    // Interrupted window: 3 high, 1 low, 4 high -> single report at 38.
    nvalid = 0;
    for (int c = 30; c <= 41; c++) begin
      goto(c);
      mon_block = ((c >= 30 && c <= 32) || (c >= 34 && c <= 37)) ? 4'b0010 : 4'b0000;
      @(negedge clock);
      if (report_valid) nvalid++;
      if (c == 37) check_eq("t2_valid_37", 64'(report_valid), 64'd0);
      if (c == 38) begin
        check_eq("t2_valid_38", 64'(report_valid), 64'd1);
        check_eq("t2_idx",      64'(report_idx),   64'd1);
        check_eq("t2_ts",       64'(report_ts),    64'd37);
      end
    end
    check_eq("t2_one_report", 64'(nvalid), 64'd1);
    goto(42); clear = 1'b1;
    goto(43); clear = 1'b0;

    // Simultaneous confirm on 3 and 1, held off by ready low for 5 cycles.
    for (int c = 50; c <= 60; c++) begin
      goto(c);
      if (c == 50) begin mon_block = 4'b1010; report_ready = 1'b0; end
      if (c == 59) report_ready = 1'b1;
      @(negedge clock);
      check_eq("t3_valid", 64'(report_valid), (c >= 54 && c <= 59) ? 64'd1 : 64'd0);
      if (c >= 54 && c <= 59) begin
        check_eq("t3_idx", 64'(report_idx), 64'd1);
        check_eq("t3_ts",  64'(report_ts),  64'd53);
      end
    end
    check_eq("t3_sticky",   64'(mon_sticky), 64'b1010);
    check_eq("t3_deadlock", 64'(deadlock),   64'd1);
    goto(61); mon_block = '0; clear = 1'b1;
    goto(62); clear = 1'b0;

    // Clear during REPORT while confirm[2] is high; window restarts after clear.
    goto(70); mon_block = 4'b0100; report_ready = 1'b0;
    goto(74); @(negedge clock);
    check_eq("t5_valid_74", 64'(report_valid), 64'd1);
    goto(75); clear = 1'b1;
    goto(76); clear = 1'b0; @(negedge clock);
    check_eq("t5_valid_76",    64'(report_valid), 64'd0);
    check_eq("t5_deadlock_76", 64'(deadlock),     64'd0);
    check_eq("t5_sticky_76",   64'(mon_sticky),   64'd0);
    goto(79); @(negedge clock);
    check_eq("t5_valid_79", 64'(report_valid), 64'd0);
    goto(80); @(negedge clock);
    check_eq("t5_valid_80", 64'(report_valid), 64'd1);
    check_eq("t5_ts_80",    64'(report_ts),    64'd79);
    check_eq("t5_idx_80",   64'(report_idx),   64'd2);
    goto(81); report_ready = 1'b1; mon_block = '0;
    goto(82); clear = 1'b1;
    goto(83); clear = 1'b0;

    // Asynchronous reset mid-REPORT, then a fresh window from cycle 0.
    goto(90); mon_block = 4'b1000; report_ready = 1'b0;
    goto(94); @(negedge clock);
    check_eq("t6_valid_pre", 64'(report_valid), 64'd1);
    #2 reset = 1'b1;
    #1;
    check_eq("t6_async_valid",    64'(report_valid), 64'd0);
    check_eq("t6_async_deadlock", 64'(deadlock),     64'd0);
    check_eq("t6_async_sticky",   64'(mon_sticky),   64'd0);
    check_eq("t6_async_idx",      64'(report_idx),   64'd0);
    check_eq("t6_async_ts",       64'(report_ts),    64'd0);
    #1 reset = 1'b0;
    goto(3); @(negedge clock);
    check_eq("t6_valid_3", 64'(report_valid), 64'd0);
    goto(4); @(negedge clock);
    check_eq("t6_valid_4",  64'(report_valid), 64'd1);
    check_eq("t6_idx_4",    64'(report_idx),   64'd3);
    check_eq("t6_ts_4",     64'(report_ts),    64'd3);
    check_eq("t6_sticky_4", 64'(mon_sticky),   64'b1000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/finn_deadlock_reporter.md
# finn_deadlock_reporter

Downstream consumer of the per-instance `block` outputs produced by the HLS deadlock monitors (one monitor tree per MVAU/FIFO/etc. instance in the FINN design wrapper). The block debounces each monitor's `block` level over a programmable persistence window. It confirms a deadlock, latches a sticky per-monitor record, and emits one report (first offending monitor index plus a cycle timestamp) over a valid/ready handshake to the debug/status register block. It sits at the top of the FINN design wrapper, outside the dataflow path, and never backpressures the dataflow.

## Interface
Parameters:
- `NUM_MON`, 8: number of monitor `block` inputs; legal range 1..256.
- `HOLD_CYCLES`, 1024: consecutive cycles a `block` input must be high to confirm; legal range 1..2^20.
- `TS_W`, 32: timestamp counter width.

Ports:
- `clock`  in  1  sole clock; all logic is rising-edge.
- `reset`  in  1  asynchronous, active-high; all state clears immediately.
- `mon_block`  in  NUM_MON  level `block` outputs of the deadlock monitors; already synchronous to `clock`.
- `clear`  in  1  single-cycle pulse that re-arms the reporter.
- `report_valid`  out  1  report available.
- `report_ready`  in  1  consumer accepts the report.
- `report_idx`  out  IDX_W  index of the reported monitor. IDX_W = max(1, clog2(NUM_MON)).
- `report_ts`  out  TS_W  timestamp-counter value in the confirm cycle.
- `deadlock`  out  1  sticky flag: a deadlock has been confirmed since the last clear.
- `mon_sticky`  out  NUM_MON  per-monitor sticky confirm bits.

## Operation
- Persistence counter per monitor, width CW = clog2(HOLD_CYCLES+1):
  - `mon_block[i]`=0 sets `cnt[i]` to 0.
  - Otherwise `cnt[i]` increments, saturating at HOLD_CYCLES-1.
- `confirm[i]` = `mon_block[i]` & (`cnt[i]` == HOLD_CYCLES-1). This is combinational. With HOLD_CYCLES=1, confirm = `mon_block`.
- Timestamp: free-running TS_W counter. It is 0 after reset, increments every cycle, and wraps modulo 2^TS_W. `clear` does not affect it.
- FSM states: IDLE, REPORT, LATCHED.
  - IDLE → REPORT when any `confirm` is high. The reporter captures the lowest confirmed index into `report_idx` and the current timestamp into `report_ts`, and sets `deadlock`.
  - REPORT: `report_valid`=1. `report_idx` and `report_ts` are held stable. REPORT → LATCHED on `report_valid` & `report_ready`.
  - LATCHED: no further reports. `report_valid`=0 and `deadlock` stays 1. Exit only via `clear`.
- `mon_sticky[i]` sets on `confirm[i]` in any state. It is cleared only by `clear` or `reset`.
- `clear` has priority over everything else. In any state, the next state is IDLE. It zeroes all `cnt`, `mon_sticky`, `deadlock`, and `report_valid`, and aborts any pending report. A `confirm` in the same cycle as `clear` is discarded.
- Confirms arriving while in REPORT or LATCHED update `mon_sticky` only. They never alter the held `report_idx`/`report_ts`.

## Timing
- Reset values:
  - `report_valid`=0, `report_idx`=0, `report_ts`=0.
  - `deadlock`=0, `mon_sticky`=0.
  - State IDLE, all counters 0.
- Latency: for `mon_block[i]` high continuously from cycle t, `confirm[i]` occurs in cycle t+HOLD_CYCLES-1. `report_valid`, `deadlock` and `mon_sticky[i]` are high from cycle t+HOLD_CYCLES.
- `report_ts` equals the timestamp at cycle t+HOLD_CYCLES-1.
- A single low cycle restarts the window. Monitors restart independently.
- Handshake: `report_valid` never drops without a transfer except on `clear` or `reset`. `report_ready` may be high before valid. With ready high, valid lasts exactly one cycle.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Structure
- Shared package `finn_deadlock_pkg` holds:
  - the state enum `dl_state_t` (IDLE, REPORT, LATCHED);
  - the function `clog2_min1` used for IDX_W and CW.
- Sub-module `finn_deadlock_persist_cnt` (parameter HOLD_CYCLES) contains one counter and its confirm output. It is instantiated NUM_MON times by generate.
- The top level contains the priority encoder (lowest index wins), the FSM, the timestamp counter, and the output registers.

## Test plan
- NUM_MON=4, HOLD_CYCLES=4, `report_ready`=1. `mon_block[2]` high from cycle 10 → `report_valid` high only in cycle 14, `report_idx`=2, `report_ts`=13, `deadlock`=1 from cycle 14, `mon_sticky`=4'b0100.
- `mon_block[1]` high for 3 cycles, low 1 cycle, then high for 4 cycles → exactly one report, and only after the second run; `report_ts` matches the last cycle of the second run.
- `mon_block[3]` and `mon_block[1]` confirm in the same cycle, with `report_ready`=0 for 5 cycles → `report_idx`=1 held stable with valid for 5 cycles, then transfers; `mon_sticky`=4'b1010.
- In LATCHED, `mon_block[0]` confirms → no new `report_valid`, `mon_sticky[0]` sets, `report_idx` unchanged.
- `clear` pulsed in REPORT while `confirm[2]` is high → next cycle `report_valid`=0, `deadlock`=0, `mon_sticky`=0, state IDLE. The timestamp keeps counting.
- `reset` asserted asynchronously mid-REPORT → all outputs 0 immediately, before the next clock edge. After release, a fresh HOLD_CYCLES window is required before any report.
